// File: rtl/sprite_pkg.sv
// Shared scancodes, decoder states, direction bit indices and the clamped axis step
// used by the sprite motion controller.
package sprite_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  // dir vector layout: {up, down, left, right}
  localparam int DIR_UP    = 3;
  localparam int DIR_DOWN  = 2;
  localparam int DIR_LEFT  = 1;
  localparam int DIR_RIGHT = 0;

  typedef enum logic [1:0] {
    DEC_IDLE    = 2'd0,
    DEC_EXT     = 2'd1,
    DEC_BRK     = 2'd2,
    DEC_EXT_BRK = 2'd3
  } dec_state_t;

  // Signed 11-bit math so a decrement near zero clamps instead of wrapping.
  function automatic logic [9:0] step_axis(input logic [9:0]        pos,
                                           input logic              dec,
                                           input logic              inc,
                                           input logic signed [10:0] lo,
                                           input logic signed [10:0] hi,
                                           input logic signed [10:0] step);
    logic signed [10:0] p;
    p = $signed({1'b0, pos});
    if (dec)      p = (p - step < lo) ? lo : p - step;
    else if (inc) p = (p + step > hi) ? hi : p + step;
    return p[9:0];
  endfunction

endpackage

// File: rtl/ps2_rx_byte.sv
// PS/2 byte receiver: synchronises the pins, shifts 11-bit frames on falling ps2_clk,
// checks start/parity/stop and aborts a stalled frame after TIMEOUT idle cycles.
module ps2_rx_byte #(
  parameter int TIMEOUT = 25000
) (
  input  logic       vga_clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic [2:0]    clk_s;   // [1:0] synchroniser, [2] previous synced value
  logic [1:0]    dat_s;
  logic [3:0]    bit_cnt;
  logic [10:0]   sr;
  logic [TW-1:0] to_cnt;
  logic          done;
  logic          fall;

  assign fall = clk_s[2] & ~clk_s[1];

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      clk_s     <= '1;
      dat_s     <= '1;
      bit_cnt   <= '0;
      sr        <= '0;
      to_cnt    <= '0;
      done      <= 1'b0;
      key_valid <= 1'b0;
      key_code  <= '0;
      frame_err <= 1'b0;
    end else begin
      clk_s     <= {clk_s[1:0], ps2_clk};
      dat_s     <= {dat_s[0], ps2_data};
      done      <= 1'b0;
      key_valid <= 1'b0;
      frame_err <= 1'b0;

      if (fall) begin
        sr     <= {dat_s[1], sr[10:1]};
        to_cnt <= '0;
        if (bit_cnt == 4'd10) begin
          bit_cnt <= '0;
          done    <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
        end
      end else if (bit_cnt != 4'd0) begin
        if (to_cnt == TW'(TIMEOUT - 1)) begin
          bit_cnt <= '0;
          to_cnt  <= '0;
        end else begin
          to_cnt <= to_cnt + TW'(1);
        end
      end

      // sr[0]=start, sr[8:1]=data, sr[9]=parity, sr[10]=stop
      if (done) begin
        if (!sr[0] && sr[10] && (^sr[9:1])) begin
          key_valid <= 1'b1;
          key_code  <= sr[8:1];
        end else begin
          frame_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/sprite_motion_ctrl.sv
// Arrow-key driven sprite mover: decodes E0/F0 scancode sequences into a held direction
// set and steps the sprite centre once per frame, clamped to the visible area.
module sprite_motion_ctrl
  import sprite_pkg::*;
#(
  parameter int H_PIXELS    = 640,
  parameter int V_PIXELS    = 480,
  parameter int SQUARE_SIZE = 10,
  parameter int INIT_X      = 320,
  parameter int INIT_Y      = 240,
  parameter int STEP        = 1,
  parameter int TIMEOUT     = 25000
) (
  input  logic       vga_clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       frame_tick,
  output logic [9:0] sq_pos_x,
  output logic [9:0] sq_pos_y,
  output logic [3:0] dir,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       frame_err
);

  localparam logic signed [10:0] X_LO = 11'(SQUARE_SIZE);
  localparam logic signed [10:0] X_HI = 11'(H_PIXELS - 1 - SQUARE_SIZE);
  localparam logic signed [10:0] Y_LO = 11'(SQUARE_SIZE);
  localparam logic signed [10:0] Y_HI = 11'(V_PIXELS - 1 - SQUARE_SIZE);
  localparam logic signed [10:0] STP  = 11'(STEP);

  dec_state_t state;

  ps2_rx_byte #(.TIMEOUT(TIMEOUT)) u_rx (
    .vga_clk  (vga_clk),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .key_valid(key_valid),
    .key_code (key_code),
    .frame_err(frame_err)
  );

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      state <= DEC_IDLE;
      dir   <= '0;
    end else if (key_valid) begin
      state <= DEC_IDLE;
      unique case (state)
        DEC_IDLE: begin
          if (key_code == SC_EXT)      state <= DEC_EXT;
          else if (key_code == SC_BRK) state <= DEC_BRK;
        end
        DEC_EXT: begin
          // A press claims its axis; the other axis is left alone for diagonals.
          case (key_code)
            SC_BRK:   state <= DEC_EXT_BRK;
            SC_UP:    begin dir[DIR_UP]    <= 1'b1; dir[DIR_DOWN]  <= 1'b0; end
            SC_DOWN:  begin dir[DIR_DOWN]  <= 1'b1; dir[DIR_UP]    <= 1'b0; end
            SC_LEFT:  begin dir[DIR_LEFT]  <= 1'b1; dir[DIR_RIGHT] <= 1'b0; end
            SC_RIGHT: begin dir[DIR_RIGHT] <= 1'b1; dir[DIR_LEFT]  <= 1'b0; end
            default:  ;
          endcase
        end
        DEC_BRK: ;
        DEC_EXT_BRK: begin
          case (key_code)
            SC_UP:    dir[DIR_UP]    <= 1'b0;
            SC_DOWN:  dir[DIR_DOWN]  <= 1'b0;
            SC_LEFT:  dir[DIR_LEFT]  <= 1'b0;
            SC_RIGHT: dir[DIR_RIGHT] <= 1'b0;
            default:  ;
          endcase
        end
        default: ;
      endcase
    end
  end

  // dir read here is the pre-update value when a key lands on the tick cycle.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      sq_pos_x <= 10'(INIT_X);
      sq_pos_y <= 10'(INIT_Y);
    end else if (frame_tick) begin
      sq_pos_x <= step_axis(sq_pos_x, dir[DIR_LEFT], dir[DIR_RIGHT], X_LO, X_HI, STP);
      sq_pos_y <= step_axis(sq_pos_y, dir[DIR_UP], dir[DIR_DOWN], Y_LO, Y_HI, STP);
    end
  end

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Directed bench for sprite_motion_ctrl: PS/2 frames bit-banged from tasks,
// hand-computed positions and direction sets checked with immediate assertions.
module tb_sprite_motion_ctrl;

  logic       vga_clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       frame_tick = 1'b0;
  logic [9:0] sq_pos_x, sq_pos_y;
  logic [3:0] dir;
  logic       key_valid, frame_err;
  logic [7:0] key_code;

  int checks = 0;
  int failures = 0;
  int kv_cnt = 0;
  int fe_cnt = 0;
  int min_x = 1023;

  sprite_motion_ctrl dut (
    .vga_clk   (vga_clk),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .frame_tick(frame_tick),
    .sq_pos_x  (sq_pos_x),
    .sq_pos_y  (sq_pos_y),
    .dir       (dir),
    .key_valid (key_valid),
    .key_code  (key_code),
    .frame_err (frame_err)
  );

  always #20 vga_clk = ~vga_clk;

  always @(negedge vga_clk) begin
    if (key_valid) kv_cnt++;
    if (frame_err) fe_cnt++;
    if (!reset && int'(sq_pos_x) < min_x) min_x = int'(sq_pos_x);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge vga_clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    cycles(10);
    ps2_clk = 1'b0;
    cycles(10);
    ps2_clk = 1'b1;
  endtask

  // First n bits of the frame for byte b; bad_par flips the parity bit.
  task automatic send_bits(input logic [7:0] b, input logic bad_par, input int n);
    logic [10:0] fr;
    fr = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < n; i++) send_bit(fr[i]);
    ps2_data = 1'b1;
    cycles(10);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(b, 1'b0, 11);
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    cycles(1);
    frame_tick = 1'b0;
    cycles(1);
  endtask

  initial begin
    int kv0;
    // 1: reset state and idle frames
    cycles(3);
    #5 reset = 1'b0;
    cycles(2);
    check("rst_x", 32'(sq_pos_x), 320);
    check("rst_y", 32'(sq_pos_y), 240);
    check("rst_dir", 32'(dir), 0);
    check("rst_kcode", 32'(key_code), 0);
    check("rst_kv", 32'(key_valid), 0);
    check("rst_ferr", 32'(frame_err), 0);
    repeat (5) tick();
    check("idle_x", 32'(sq_pos_x), 320);
    check("idle_y", 32'(sq_pos_y), 240);
    check("idle_dir", 32'(dir), 0);

    // 2: press up, 3 frames, release
    send_byte(8'hE0);
    send_byte(8'h75);
    check("up_kv_cnt", 32'(kv_cnt), 2);
    check("up_kcode", 32'(key_code), 32'h75);
    check("up_dir", 32'(dir), 4'b1000);
    repeat (3) tick();
    check("up_y", 32'(sq_pos_y), 237);
    check("up_x", 32'(sq_pos_x), 320);
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h75);
    check("uprel_dir", 32'(dir), 0);
    tick();
    check("uprel_y", 32'(sq_pos_y), 237);

    // 3: hold left into the clamp
    send_byte(8'hE0);
    send_byte(8'h6B);
    check("left_dir", 32'(dir), 4'b0010);
    min_x = 1023;
    repeat (400) tick();
    check("left_x_clamp", 32'(sq_pos_x), 10);
    check("left_x_min", 32'(min_x), 10);
    check("left_y", 32'(sq_pos_y), 237);
    check("left_dir_hold", 32'(dir), 4'b0010);

    // 4: E0 then a corrupted 75 must not press up; decoder stays in EXT
    send_byte(8'hE0);
    kv0 = kv_cnt;
    fe_cnt = 0;
    send_bits(8'h75, 1'b1, 11);
    check("par_ferr_cnt", 32'(fe_cnt), 1);
    check("par_kv_cnt", 32'(kv_cnt - kv0), 0);
    check("par_kcode", 32'(key_code), 32'hE0);
    check("par_dir", 32'(dir), 4'b0010);
    send_byte(8'h75);
    check("par_ext_dir", 32'(dir), 4'b1010);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h6B);
    check("par_rel_dir", 32'(dir), 0);

    // 5: stalled partial frame is abandoned after the timeout
    fe_cnt = 0;
    kv0 = kv_cnt;
    send_bits(8'hE0, 1'b0, 5);
    cycles(25010);
    send_byte(8'hE0);
    send_byte(8'h74);
    check("to_dir", 32'(dir), 4'b0001);
    check("to_ferr_cnt", 32'(fe_cnt), 0);
    check("to_kv_cnt", 32'(kv_cnt - kv0), 2);

    // 6: opposite press overrides, then async reset mid-byte
    send_byte(8'hE0); send_byte(8'h75);
    send_byte(8'hE0); send_byte(8'h72);
    check("ud_dir", 32'(dir), 4'b0101);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h74);
    check("ud_dir_only", 32'(dir), 4'b0100);
    repeat (2) tick();
    check("ud_y", 32'(sq_pos_y), 239);
    send_bits(8'h6B, 1'b0, 4);
    #7 reset = 1'b1;
    #3;
    check("mrst_x", 32'(sq_pos_x), 320);
    check("mrst_y", 32'(sq_pos_y), 240);
    check("mrst_dir", 32'(dir), 0);
    check("mrst_kcode", 32'(key_code), 0);
    cycles(3);
    #5 reset = 1'b0;
    cycles(2);
    send_byte(8'hE0);
    send_byte(8'h74);
    check("post_dir", 32'(dir), 4'b0001);
    check("post_kcode", 32'(key_code), 32'h74);
    tick();
    check("post_x", 32'(sq_pos_x), 321);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
